mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates a load/store port and an instruction-fetch port onto a
// byte-wide synchronous RAM (one-cycle read latency), one byte per cycle.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] data_to_mem_i,
    input  logic [2:0]  mem_times_i,
    input  logic [1:0]  mem_readwrite_i,
    output logic [31:0] data_from_mem_o,
    output logic [1:0]  mem_status_o,
    input  logic [31:0] if_addr_i,
    input  logic        if_req_i,
    output logic [31:0] if_data_o,
    output logic [1:0]  if_status_o,
    input  logic [7:0]  ram_din_i,
    output logic [7:0]  ram_dout_o,
    output logic [31:0] ram_a_o,
    output logic        ram_wr_o
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned CW = 3;

    localparam logic [1:0] ST_INIT  = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] size_q, size_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [CW-1:0] cap_cnt_q, cap_cnt_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          port_if_q, port_if_d;
    logic          addr_vld_q, addr_vld_d;
    logic          din_vld_q, din_vld_d;

    logic [AW-1:0] ram_a_d;
    logic          ram_wr_d;
    logic [BW-1:0] ram_dout_d;
    logic [DW-1:0] mem_data_d, if_data_d;
    logic [1:0]    mem_status_d, if_status_d, served_st;
    logic          mem_req, size_ok;

    assign mem_req = (mem_readwrite_i == RW_READ) || (mem_readwrite_i == RW_WRITE);
    assign size_ok = (mem_times_i == CW'(1)) || (mem_times_i == CW'(2)) ||
                     (mem_times_i == CW'(4));

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            size_q          <= '0;
            byte_cnt_q      <= '0;
            cap_cnt_q       <= '0;
            wdata_q         <= '0;
            rdata_q         <= '0;
            port_if_q       <= 1'b0;
            addr_vld_q      <= 1'b0;
            din_vld_q       <= 1'b0;
            ram_a_o         <= '0;
            ram_wr_o        <= 1'b0;
            ram_dout_o      <= '0;
            data_from_mem_o <= '0;
            if_data_o       <= '0;
            mem_status_o    <= ST_INIT;
            if_status_o     <= ST_INIT;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            size_q          <= size_d;
            byte_cnt_q      <= byte_cnt_d;
            cap_cnt_q       <= cap_cnt_d;
            wdata_q         <= wdata_d;
            rdata_q         <= rdata_d;
            port_if_q       <= port_if_d;
            addr_vld_q      <= addr_vld_d;
            din_vld_q       <= din_vld_d;
            ram_a_o         <= ram_a_d;
            ram_wr_o        <= ram_wr_d;
            ram_dout_o      <= ram_dout_d;
            data_from_mem_o <= mem_data_d;
            if_data_o       <= if_data_d;
            mem_status_o    <= mem_status_d;
            if_status_o     <= if_status_d;
        end
    end

    // Next state and next output values; RAM bus idles at zero
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        byte_cnt_d = byte_cnt_q;
        cap_cnt_d  = cap_cnt_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        port_if_d  = port_if_q;
        addr_vld_d = 1'b0;
        din_vld_d  = addr_vld_q;
        ram_a_d    = '0;
        ram_wr_d   = 1'b0;
        ram_dout_d = '0;
        mem_data_d = data_from_mem_o;
        if_data_d  = if_data_o;
        served_st  = ST_INIT;

        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    addr_d    = mem_addr_i;
                    size_d    = mem_times_i;
                    wdata_d   = data_to_mem_i;
                    port_if_d = 1'b0;
                    if (!size_ok) begin
                        state_d    = DONE;
                        served_st  = ST_DONE;
                        mem_data_d = '0;
                    end else begin
                        served_st  = ST_BUSY;
                        byte_cnt_d = CW'(1);
                        cap_cnt_d  = '0;
                        ram_a_d    = mem_addr_i;
                        if (mem_readwrite_i == RW_WRITE) begin
                            state_d    = WRITE;
                            ram_wr_d   = 1'b1;
                            ram_dout_d = data_to_mem_i[BW-1:0];
                        end else begin
                            state_d    = READ;
                            addr_vld_d = 1'b1;
                            rdata_d    = '0;
                        end
                    end
                end else if (if_req_i) begin
                    addr_d     = if_addr_i;
                    size_d     = CW'(4);
                    port_if_d  = 1'b1;
                    served_st  = ST_BUSY;
                    byte_cnt_d = CW'(1);
                    cap_cnt_d  = '0;
                    rdata_d    = '0;
                    ram_a_d    = if_addr_i;
                    addr_vld_d = 1'b1;
                    state_d    = READ;
                end
            end
            READ: begin
                served_st = ST_BUSY;
                if (byte_cnt_q < size_q) begin
                    ram_a_d    = addr_q + AW'(byte_cnt_q);
                    addr_vld_d = 1'b1;
                    byte_cnt_d = byte_cnt_q + CW'(1);
                end
                // RAM data trails its address by one cycle
                if (din_vld_q) begin
                    rdata_d[{cap_cnt_q[1:0], 3'b000} +: BW] = ram_din_i;
                    cap_cnt_d = cap_cnt_q + CW'(1);
                    if (cap_cnt_d == size_q) begin
                        state_d   = DONE;
                        served_st = ST_DONE;
                        if (port_if_q) begin
                            if_data_d = rdata_d;
                        end else begin
                            mem_data_d = rdata_d;
                        end
                    end
                end
            end
            WRITE: begin
                if (byte_cnt_q < size_q) begin
                    served_st  = ST_BUSY;
                    ram_a_d    = addr_q + AW'(byte_cnt_q);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = wdata_q[{byte_cnt_q[1:0], 3'b000} +: BW];
                    byte_cnt_d = byte_cnt_q + CW'(1);
                end else begin
                    state_d   = DONE;
                    served_st = ST_DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_status_d = port_if_d ? ST_INIT : served_st;
        if_status_d  = port_if_d ? served_st : ST_INIT;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and random transfers through mem_ctrl, checked
// cycle by cycle against a byte-array memory model and the port timing rules.
module tb_mem_ctrl;

    localparam logic [1:0] S_INIT = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr_i, data_to_mem_i, if_addr_i;
    logic [2:0]  mem_times_i;
    logic [1:0]  mem_readwrite_i;
    logic        if_req_i;
    logic [31:0] data_from_mem_o, if_data_o, ram_a_o;
    logic [1:0]  mem_status_o, if_status_o;
    logic [7:0]  ram_din_i, ram_dout_o;
    logic        ram_wr_o;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram_arr [int unsigned];
    logic [7:0]  ref_mem [int unsigned];
    logic [31:0] exp_mem_data, exp_if_data;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_addr_i(mem_addr_i), .data_to_mem_i(data_to_mem_i),
        .mem_times_i(mem_times_i), .mem_readwrite_i(mem_readwrite_i),
        .data_from_mem_o(data_from_mem_o), .mem_status_o(mem_status_o),
        .if_addr_i(if_addr_i), .if_req_i(if_req_i),
        .if_data_o(if_data_o), .if_status_o(if_status_o),
        .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o),
        .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o)
    );

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_arr.exists(a)) return ram_arr[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    // Byte RAM on the DUT side: registered read, write on strobe
    always @(posedge clk) begin
        ram_din_i <= ram_rd(ram_a_o);
        if (ram_wr_o) ram_arr[ram_a_o] = ram_dout_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        mem_addr_i      = $urandom;
        data_to_mem_i   = $urandom;
        mem_times_i     = 3'($urandom);
        mem_readwrite_i = 2'($urandom);
        if_addr_i       = $urandom;
        if_req_i        = 1'($urandom);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ":idle_wr"}, 32'(ram_wr_o), 32'd0);
        chk({tag, ":idle_a"}, ram_a_o, 32'd0);
        chk({tag, ":idle_mst"}, 32'(mem_status_o), 32'(S_INIT));
        chk({tag, ":idle_ist"}, 32'(if_status_o), 32'(S_INIT));
        chk({tag, ":idle_mdata"}, data_from_mem_o, exp_mem_data);
        chk({tag, ":idle_idata"}, if_data_o, exp_if_data);
    endtask

    // Starts in an IDLE cycle, presents a request, follows it to the next IDLE cycle
    task automatic xfer(input string tag, input bit is_if, input bit is_wr,
                        input logic [2:0] n, input logic [31:0] a, input logic [31:0] d,
                        input bit if_too, input bit next_if);
        logic [31:0] ev;
        logic [1:0]  busy_m, busy_i;
        int          nb;
        bit          valid;
        if (is_if) begin
            mem_readwrite_i = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            mem_addr_i      = $urandom;
            if_req_i        = 1'b1;
            if_addr_i       = a;
            nb              = 4;
            valid           = 1'b1;
        end else begin
            mem_readwrite_i = is_wr ? 2'b10 : 2'b01;
            mem_addr_i      = a;
            data_to_mem_i   = d;
            mem_times_i     = n;
            if_req_i        = if_too;
            if_addr_i       = $urandom;
            nb              = int'(n);
            valid           = (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
        end
        step();
        scramble();
        if (!valid) begin
            chk({tag, ":inv_mst"}, 32'(mem_status_o), 32'(S_DONE));
            chk({tag, ":inv_ist"}, 32'(if_status_o), 32'(S_INIT));
            chk({tag, ":inv_data"}, data_from_mem_o, 32'd0);
            chk({tag, ":inv_wr"}, 32'(ram_wr_o), 32'd0);
            chk({tag, ":inv_a"}, ram_a_o, 32'd0);
            exp_mem_data = 32'd0;
        end else if (is_wr) begin
            for (int k = 0; k < nb; k++) begin
                chk({tag, ":w_wr"}, 32'(ram_wr_o), 32'd1);
                chk({tag, ":w_a"}, ram_a_o, a + 32'(k));
                chk({tag, ":w_dout"}, 32'(ram_dout_o), 32'(8'(d >> (8 * k))));
                chk({tag, ":w_mst"}, 32'(mem_status_o), 32'(S_BUSY));
                chk({tag, ":w_ist"}, 32'(if_status_o), 32'(S_INIT));
                ref_mem[a + 32'(k)] = 8'(d >> (8 * k));
                step();
                scramble();
            end
            chk({tag, ":w_end_wr"}, 32'(ram_wr_o), 32'd0);
            chk({tag, ":w_done"}, 32'(mem_status_o), 32'(S_DONE));
            chk({tag, ":w_done_ist"}, 32'(if_status_o), 32'(S_INIT));
            chk({tag, ":w_mdata_hold"}, data_from_mem_o, exp_mem_data);
        end else begin
            ev = 32'd0;
            for (int k = 0; k < nb; k++) ev = ev | (32'(ref_rd(a + 32'(k))) << (8 * k));
            busy_m = is_if ? S_INIT : S_BUSY;
            busy_i = is_if ? S_BUSY : S_INIT;
            for (int k = 0; k < nb; k++) begin
                chk({tag, ":r_a"}, ram_a_o, a + 32'(k));
                chk({tag, ":r_wr"}, 32'(ram_wr_o), 32'd0);
                chk({tag, ":r_mst"}, 32'(mem_status_o), 32'(busy_m));
                chk({tag, ":r_ist"}, 32'(if_status_o), 32'(busy_i));
                step();
                scramble();
            end
            chk({tag, ":r_last_mst"}, 32'(mem_status_o), 32'(busy_m));
            chk({tag, ":r_last_ist"}, 32'(if_status_o), 32'(busy_i));
            chk({tag, ":r_last_wr"}, 32'(ram_wr_o), 32'd0);
            step();
            scramble();
            if (is_if) begin
                chk({tag, ":if_done"}, 32'(if_status_o), 32'(S_DONE));
                chk({tag, ":if_done_mst"}, 32'(mem_status_o), 32'(S_INIT));
                chk({tag, ":if_data"}, if_data_o, ev);
                chk({tag, ":if_mdata_hold"}, data_from_mem_o, exp_mem_data);
                exp_if_data = ev;
            end else begin
                chk({tag, ":m_done"}, 32'(mem_status_o), 32'(S_DONE));
                chk({tag, ":m_done_ist"}, 32'(if_status_o), 32'(S_INIT));
                chk({tag, ":m_data"}, data_from_mem_o, ev);
                chk({tag, ":m_idata_hold"}, if_data_o, exp_if_data);
                exp_mem_data = ev;
            end
        end
        mem_readwrite_i = 2'b00;
        if_req_i        = next_if;
        step();
        chk_idle(tag);
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] ra;
        int          kind;

        rst = 1'b0;
        mem_addr_i = '0; data_to_mem_i = '0; mem_times_i = '0;
        mem_readwrite_i = 2'b00; if_addr_i = '0; if_req_i = 1'b0;
        exp_mem_data = '0;
        exp_if_data  = '0;
        ram_arr[32'h100] = 8'h78; ram_arr[32'h101] = 8'h56;
        ram_arr[32'h102] = 8'h34; ram_arr[32'h103] = 8'h12;
        ref_mem[32'h100] = 8'h78; ref_mem[32'h101] = 8'h56;
        ref_mem[32'h102] = 8'h34; ref_mem[32'h103] = 8'h12;
        step();
        step();
        chk_idle("reset");
        chk("reset:dout", 32'(ram_dout_o), 32'd0);

        // LW at 0x100 presented together with reset release
        rst = 1'b1;
        xfer("lw", 1'b0, 1'b0, 3'd4, 32'h100, 32'd0, 1'b0, 1'b0);
        chk("lw:const", data_from_mem_o, 32'h1234_5678);

        xfer("sh", 1'b0, 1'b1, 3'd2, 32'h200, 32'hAABB_CCDD, 1'b0, 1'b0);
        chk("sh:byte0", 32'(ram_rd(32'h200)), 32'h0000_00DD);
        chk("sh:byte1", 32'(ram_rd(32'h201)), 32'h0000_00CC);
        xfer("sh_rb", 1'b0, 1'b0, 3'd2, 32'h200, 32'd0, 1'b0, 1'b0);
        chk("sh_rb:const", data_from_mem_o, 32'h0000_CCDD);

        // MEM beats IF in the same cycle; IF is accepted right after
        xfer("prio_lb", 1'b0, 1'b0, 3'd1, 32'h10, 32'd0, 1'b1, 1'b1);
        xfer("prio_if", 1'b1, 1'b0, 3'd4, 32'h400, 32'd0, 1'b0, 1'b0);

        // Reset in cycle 2 of a LW
        mem_readwrite_i = 2'b01; mem_times_i = 3'd4; mem_addr_i = 32'h300;
        step();
        step();
        mem_readwrite_i = 2'b00;
        rst = 1'b0;
        step();
        exp_mem_data = '0;
        exp_if_data  = '0;
        chk_idle("rst_mid");
        chk("rst_mid:dout", 32'(ram_dout_o), 32'd0);
        rst = 1'b1;
        xfer("rst_lb", 1'b0, 1'b0, 3'd1, 32'h301, 32'd0, 1'b0, 1'b0);

        xfer("wrap_lh", 1'b0, 1'b0, 3'd2, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0);
        chk("wrap_lh:zext", 32'(data_from_mem_o[31:16]), 32'd0);

        xfer("inv3", 1'b0, 1'b0, 3'd3, 32'h500, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 9));
            case ($urandom_range(0, 2))
                0: sz = 3'd1;
                1: sz = 3'd2;
                default: sz = 3'd4;
            endcase
            ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                             : 32'h1000 + 32'($urandom_range(0, 31));
            if (kind < 3) begin
                xfer("rnd_if", 1'b1, 1'b0, 3'd4, ra, 32'd0, 1'b0, 1'b0);
            end else if (kind < 6) begin
                xfer("rnd_rd", 1'b0, 1'b0, sz, ra, 32'd0, 1'($urandom), 1'b0);
            end else if (kind < 9) begin
                xfer("rnd_wr", 1'b0, 1'b1, sz, ra, $urandom, 1'($urandom), 1'b0);
            end else begin
                case ($urandom_range(0, 4))
                    0: sz = 3'd0;
                    1: sz = 3'd3;
                    2: sz = 3'd5;
                    3: sz = 3'd6;
                    default: sz = 3'd7;
                endcase
                xfer("rnd_inv", 1'b0, 1'($urandom), sz, ra, $urandom, 1'($urandom), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
